// File: rtl/mem_stage.sv
// MIPS memory stage: word-addressed data RAM below MMIO_BASE, and above it a
// STATUS/DROPCLR register pair plus a posted-write queue drained over valid/ready.
module mem_stage #(
    parameter int unsigned RAM_WORDS  = 64,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_wmem_i,
    input  logic [31:0] alu_out_i32,
    input  logic [31:0] write_data_i32,
    output logic [31:0] read_data_o32,
    output logic        mmio_valid_o,
    input  logic        mmio_ready_i,
    output logic [15:0] mmio_addr_o16,
    output logic [31:0] mmio_data_o32,
    output logic [7:0]  drop_count_o8
);

    localparam int unsigned IW = $clog2(RAM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } mmio_req_t;

    logic [31:0]   ram_q  [RAM_WORDS];
    mmio_req_t     fifo_q [FIFO_DEPTH];

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    drop_q, drop_d;

    logic          is_mmio, is_reg, is_queue, reg_status, reg_dropclr;
    logic          full, pop, push_req, push, drop;
    logic [15:0]   offset;
    logic [IW-1:0] ram_idx;
    mmio_req_t     head;

    assign is_mmio     = alu_out_i32 >= MMIO_BASE;
    assign offset      = alu_out_i32[15:0];
    assign ram_idx     = alu_out_i32[IW+1:2];
    assign is_reg      = is_mmio && (offset[15:4] == 12'h000);
    assign is_queue    = is_mmio && !is_reg;
    assign reg_status  = is_reg && (offset[3:2] == 2'd0);
    assign reg_dropclr = is_reg && (offset[3:2] == 2'd1);

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign pop      = mmio_valid_o && mmio_ready_i;
    assign push_req = enable_wmem_i && is_queue;
    // A full queue still takes a store when the head leaves on the same edge.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        drop_d  = drop_q;
        if (push) wptr_d = wptr_q + PW'(1);
        if (pop)  rptr_d = rptr_q + PW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
        if (enable_wmem_i && reg_dropclr)  drop_d = 8'd0;
        else if (drop && drop_q != 8'hFF)  drop_d = drop_q + 8'd1;
        if (!reset_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            drop_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        count_q <= count_d;
        drop_q  <= drop_d;
    end

    // Storage arrays carry no reset; stores seen during reset are discarded.
    always_ff @(posedge clk_i) begin
        if (reset_i && enable_wmem_i && !is_mmio) ram_q[ram_idx] <= write_data_i32;
        if (reset_i && push) fifo_q[wptr_q] <= {offset, write_data_i32};
    end

    assign head          = fifo_q[rptr_q];
    assign mmio_valid_o  = (count_q != '0);
    assign mmio_addr_o16 = mmio_valid_o ? head.addr : 16'h0000;
    assign mmio_data_o32 = mmio_valid_o ? head.data : 32'h0;
    assign drop_count_o8 = drop_q;

    always_comb begin
        read_data_o32 = 32'h0;
        if (!is_mmio)        read_data_o32 = ram_q[ram_idx];
        else if (reg_status) read_data_o32 = {16'h0000, drop_q, 8'(count_q)};
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-stage block of the pipelined MIPS core, sitting directly downstream of the data path's EX/MEM register: it consumes the MEM-stage ALU result (address), store data and store enable, and returns load data to the MEM/WB register. Addresses below `MMIO_BASE` hit a word-addressed on-chip data RAM. Addresses at or above it hit a small MMIO window: a status/control register pair plus a posted-write queue drained to an external peripheral bus over a valid/ready handshake. No pipeline stall is produced; overflowing MMIO stores are dropped and counted.

## Interface
- `RAM_WORDS`, 64, data RAM depth in 32-bit words; power of 2, ≥ 4.
- `MMIO_BASE`, 32'hFFFF_0000, first MMIO byte address; low 16 bits zero.
- `FIFO_DEPTH`, 4, posted-write queue entries; power of 2, ≥ 2.
- `clk_i`  in  1  single clock; all state updates on rising edge.
- `reset_i`  in  1  synchronous, active-low reset.
- `enable_wmem_i`  in  1  store strobe from MEM stage.
- `alu_out_i32`  in  32  byte address from MEM stage.
- `write_data_i32`  in  32  store data from MEM stage.
- `read_data_o32`  out  32  load data to MEM/WB register (combinational).
- `mmio_valid_o`  out  1  queue head valid.
- `mmio_ready_i`  in  1  peripheral accepts head.
- `mmio_addr_o16`  out  16  head address offset (addr[15:0]).
- `mmio_data_o32`  out  32  head store data.
- `drop_count_o8`  out  8  current dropped-store count (debug).

## Operation
- Region decode: `is_mmio = alu_out_i32 >= MMIO_BASE` (unsigned). Offset = `alu_out_i32[15:0]`.
- RAM: index = `alu_out_i32[log2(RAM_WORDS)+1:2]`; upper bits and addr[1:0] ignored (aliasing/wrap intended). Store writes on the edge when `enable_wmem_i && !is_mmio`. Read is combinational. RAM contents are not reset.
- MMIO registers (offsets 0x00-0x0F, word-aligned, addr[1:0] ignored):
  - 0x00 STATUS, read-only: [15:8] drop_count, [7:0] queue occupancy; other bits 0. Stores ignored.
  - 0x04 DROPCLR: any store clears drop_count; reads 0.
  - 0x08, 0x0C: reserved, read 0, stores ignored.
- MMIO queue (offsets ≥ 0x10): a store pushes {offset, data} into the FIFO.
  - Push accepted if not full, or full with a pop in the same cycle.
  - Full and no pop: store dropped; drop_count increments, saturating at 255.
  - Same-cycle DROPCLR store and a drop cannot occur (one store per cycle).
- Loads from offsets ≥ 0x10 return 0 (write-only window).
- Pop: `mmio_valid_o && mmio_ready_i`. Head outputs hold stable while valid and not ready.
- Occupancy counter 0..FIFO_DEPTH; push-only +1, pop-only −1, both: unchanged. Read/write pointers wrap modulo FIFO_DEPTH.
- Reset (`reset_i` low at an edge): pointers, occupancy, drop_count → 0; `mmio_valid_o` → 0; an in-flight head is discarded. A store presented during reset is ignored.

## Timing
- RAM load: same-cycle combinational; load and store to same word in one cycle returns old data; new data visible next cycle.
- STATUS read reflects register state before the current edge.
- MMIO push at edge N → `mmio_valid_o` = 1 from cycle N+1 (one-cycle latency) if queue was empty.
- Pop at edge N → next entry (or valid = 0) presented from cycle N+1. Throughput: one push and one pop per cycle.
- Reset outputs: `mmio_valid_o` 0, `drop_count_o8` 0, `mmio_addr_o16`/`mmio_data_o32` 0; `read_data_o32` follows RAM/registers combinationally.

## Test plan
- RAM: store 0xDEADBEEF to 0x0000_0010, load 0x10 next cycle → 0xDEADBEEF; load 0x0000_0110 (RAM_WORDS=64) → 0xDEADBEEF (alias); same-cycle load/store to 0x20 returns prior value.
- MMIO push: `mmio_ready_i`=0, store 0x11 to 0xFFFF_0010 → next cycle `mmio_valid_o`=1, addr 0x0010, data 0x11; STATUS reads 0x0000_0001; raise ready one cycle → valid drops, STATUS 0.
- Overflow: ready=0, six stores to 0xFFFF_0020 → occupancy 4, `drop_count_o8`=2; STATUS = 0x0000_0204; store to 0xFFFF_0004 → drop_count 0.
- Full with simultaneous pop: queue full, ready=1, store in same cycle → accepted, occupancy stays 4, no drop; drained order matches push order.
- Saturation: 300 drops with queue full → `drop_count_o8` = 255.
- Reset mid-operation: queue holding 3 entries, assert `reset_i`=0 one edge → `mmio_valid_o` 0, STATUS 0; previously stored RAM word still readable.
